multi_lane_writeback: RTL and testbench
=======================================

MULTI_LANE_WRITEBACK -- requirements
Module: multi_lane_writeback

Interface
REQ-001 SHALL have parameter NUM_LANES, default 2, meaning number of result lanes; lane 0 is oldest in program order.
REQ-002 SHALL have parameter NUM_WR_PORTS, default 1, meaning register-file write ports per cycle; legal range 1..NUM_LANES.
REQ-003 SHALL have parameter HIST_DEPTH, default 4, meaning forwarding-history entries.
REQ-004 SHALL have ports, one per line (name, direction, width, meaning):
  clk  in  1  clock
  rst  in  1  reset, synchronous, active-high
  lane_valid  in  NUM_LANES  result present per lane
  lane_ready  out  NUM_LANES  lane consumed this cycle
  lane_result  in  NUM_LANES x 64  result value or branch target
  lane_is_branch  in  NUM_LANES  result is branch target
  lane_write_rd  in  NUM_LANES  write destination register
  lane_rd  in  NUM_LANES x 5  destination index
  lane_end_program  in  NUM_LANES  lane terminates program
  rf_we  out  NUM_WR_PORTS  register write enable
  rf_waddr  out  NUM_WR_PORTS x 5  register index
  rf_wdata  out  NUM_WR_PORTS x 64  register value
  pc_write_en  out  1  redirect PC
  pc_write  out  64  redirect target
  done_executing  out  1  sticky program-end flag
  hist_rd  out  HIST_DEPTH x 5  history indices, entry 0 newest
  hist_value  out  HIST_DEPTH x 64  history values
  hist_valid  out  HIST_DEPTH  history entry valid

Function
REQ-005 Lane i SHALL be accepted (lane_ready[i]=1) only if lane_valid[i], all older valid lanes are accepted, done_executing=0, and the write-port count is not exhausted.
REQ-006 A lane SHALL consume a write port iff lane_write_rd=1 and lane_rd!=0; lanes with rd=0 or write_rd=0 SHALL be accepted without consuming a port.
REQ-007 Accepted writing lanes SHALL map to write ports in lane order, port 0 taking the oldest.
REQ-008 Register writes SHALL appear on rf_* exactly one cycle after acceptance (registered outputs); unused ports SHALL drive rf_we=0, rf_waddr=0, rf_wdata=0.
REQ-009 Written value SHALL be {result[63:1],1'b0}+4 when lane_is_branch=1, else result, 64-bit wrap.
REQ-010 The oldest accepted branch lane SHALL set pc_write_en=1 and pc_write={result[63:1],1'b0}, registered, one cycle after acceptance.
REQ-011 Lanes younger than an accepted branch or end_program lane in the same cycle SHALL get lane_ready=0 and produce no write.
REQ-012 An accepted lane with lane_end_program=1 SHALL set done_executing the following cycle; done_executing SHALL stay 1 until reset, and every lane_ready SHALL be 0 thereafter.
REQ-013 The history buffer SHALL shift by the number of ports written per cycle; new entries enter at index 0 in youngest-first order; entries beyond HIST_DEPTH are dropped.
REQ-014 With zero writes in a cycle, history SHALL hold.
REQ-015 lane_ready SHALL be combinational from the lane inputs and done_executing, with no dependence on any other state.

Reset
REQ-016 On rst, rf_we, pc_write_en, done_executing and hist_valid SHALL be 0; rf_waddr, rf_wdata, pc_write, hist_rd and hist_value SHALL be 0.
REQ-017 rst asserted during a cycle with accepted lanes SHALL discard them; no write or redirect SHALL appear afterwards.

Configuration
REQ-018 Macro WB_HISTORY_EN SHALL compile the history buffer in; without it, hist_valid, hist_rd and hist_value SHALL be tied to 0 and no history flops SHALL exist.

Structure
REQ-019 Type double_word (64-bit) and the reg_idx_t (5-bit) type SHALL live in the shared cpu_pkg package.
REQ-020 The history shift register SHALL be a sub-module wb_history_buffer parameterised by HIST_DEPTH and NUM_WR_PORTS.

Verification
REQ-021 Setup NUM_LANES=2, NUM_WR_PORTS=1; both lanes valid, write rd=5 and rd=6 -> lane_ready=01, port 0 writes x5 next cycle, lane 1 is accepted the following cycle.
REQ-022 Lane 0 branch, result 0x1001, rd=1 -> next cycle pc_write=0x1000, rf_wdata=0x1004, rf_waddr=1.
REQ-023 Lane 0 branch and lane 1 valid write rd=7 -> lane 1 not accepted, no write to x7.
REQ-024 Lane 0 writes rd=0, value 0xFF -> lane_ready=1, rf_we=0, history unchanged.
REQ-025 Lane 0 end_program -> done_executing=1 next cycle; further valid lanes see lane_ready=0 until rst.
REQ-026 HIST_DEPTH=4; five successive writes x1..x5 -> hist_rd={5,4,3,2}, all hist_valid=1.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU types: 64-bit data word, 5-bit register index, and the
// register-file write request used by the writeback path.
package cpu_pkg;

    typedef logic [63:0] double_word;
    typedef logic [4:0]  reg_idx_t;

    typedef struct packed {
        logic       we;
        reg_idx_t   addr;
        double_word data;
    } rf_wr_t;

    localparam reg_idx_t REG_ZERO = 5'd0;

    // Branch results carry the raw target; bit 0 is never a valid PC bit.
    function automatic double_word branch_target(input double_word r);
        return {r[63:1], 1'b0};
    endfunction

endpackage

// File: rtl/multi_lane_writeback_if.sv
// Lane-result handshake between the execute lanes (master) and the
// writeback stage (slave). Lane 0 is the oldest in program order.
interface multi_lane_writeback_if #(
    parameter int NUM_LANES = 2
);
    import cpu_pkg::*;

    logic       [NUM_LANES-1:0] lane_valid;
    logic       [NUM_LANES-1:0] lane_ready;
    double_word [NUM_LANES-1:0] lane_result;
    logic       [NUM_LANES-1:0] lane_is_branch;
    logic       [NUM_LANES-1:0] lane_write_rd;
    reg_idx_t   [NUM_LANES-1:0] lane_rd;
    logic       [NUM_LANES-1:0] lane_end_program;

    modport master (
        output lane_valid, lane_result, lane_is_branch, lane_write_rd,
               lane_rd, lane_end_program,
        input  lane_ready
    );

    modport slave (
        input  lane_valid, lane_result, lane_is_branch, lane_write_rd,
               lane_rd, lane_end_program,
        output lane_ready
    );

endinterface

// File: rtl/wb_history_buffer.sv
// Forwarding history of recent register writes, entry 0 newest. Only built
// when WB_HISTORY_EN is defined; otherwise this file contributes nothing.
`ifdef WB_HISTORY_EN
module wb_history_buffer
    import cpu_pkg::*;
#(
    parameter int HIST_DEPTH   = 4,
    parameter int NUM_WR_PORTS = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  rf_wr_t     [NUM_WR_PORTS-1:0]      wr,
    output reg_idx_t   [HIST_DEPTH-1:0]        hist_rd,
    output double_word [HIST_DEPTH-1:0]        hist_value,
    output logic       [HIST_DEPTH-1:0]        hist_valid
);

    reg_idx_t   [HIST_DEPTH-1:0] rd_q,  rd_d;
    double_word [HIST_DEPTH-1:0] val_q, val_d;
    logic       [HIST_DEPTH-1:0] vld_q, vld_d;

    // Ports are filled oldest-first, so the last used port is the youngest
    // write and lands at entry 0; older entries slide down by the count.
    always_comb begin
        int n;
        n = 0;
        for (int p = 0; p < NUM_WR_PORTS; p++)
            if (wr[p].we) n = n + 1;
        rd_d  = '0;
        val_d = '0;
        vld_d = '0;
        for (int j = 0; j < HIST_DEPTH; j++) begin
            if (j < n) begin
                for (int p = 0; p < NUM_WR_PORTS; p++) begin
                    if (p == n - 1 - j) begin
                        rd_d[j]  = wr[p].addr;
                        val_d[j] = wr[p].data;
                        vld_d[j] = 1'b1;
                    end
                end
            end else begin
                for (int k = 0; k < HIST_DEPTH; k++) begin
                    if (k == j - n) begin
                        rd_d[j]  = rd_q[k];
                        val_d[j] = val_q[k];
                        vld_d[j] = vld_q[k];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q  <= '0;
            val_q <= '0;
            vld_q <= '0;
        end else begin
            rd_q  <= rd_d;
            val_q <= val_d;
            vld_q <= vld_d;
        end
    end

    assign hist_rd    = rd_q;
    assign hist_value = val_q;
    assign hist_valid = vld_q;

endmodule
`endif

// File: rtl/wb_lane.sv
// Per-lane decode: register write value, redirect target, and whether the
// lane needs a register-file write port.
module wb_lane
    import cpu_pkg::*;
(
    input  double_word result,
    input  logic       is_branch,
    input  logic       write_rd,
    input  reg_idx_t   rd,
    output logic       uses_port,
    output double_word wr_val,
    output double_word target
);

    assign target    = branch_target(result);
    // A branch links the return address, i.e. the target plus one instruction.
    assign wr_val    = is_branch ? target + 64'd4 : result;
    assign uses_port = write_rd && (rd != REG_ZERO);

endmodule

// File: rtl/multi_lane_writeback.sv
// Multi-lane writeback: in-order lane acceptance, write-port allocation,
// PC redirect and program-end latch. History buffer under WB_HISTORY_EN.
module multi_lane_writeback
    import cpu_pkg::*;
#(
    parameter int NUM_LANES    = 2,
    parameter int NUM_WR_PORTS = 1,
    parameter int HIST_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    multi_lane_writeback_if.slave         lanes,
    output logic       [NUM_WR_PORTS-1:0] rf_we,
    output reg_idx_t   [NUM_WR_PORTS-1:0] rf_waddr,
    output double_word [NUM_WR_PORTS-1:0] rf_wdata,
    output logic                          pc_write_en,
    output double_word                    pc_write,
    output logic                          done_executing,
    output reg_idx_t   [HIST_DEPTH-1:0]   hist_rd,
    output double_word [HIST_DEPTH-1:0]   hist_value,
    output logic       [HIST_DEPTH-1:0]   hist_valid
);

    logic       [NUM_LANES-1:0]    uses_port;
    double_word [NUM_LANES-1:0]    wr_val;
    double_word [NUM_LANES-1:0]    target;
    logic       [NUM_LANES-1:0]    ready;
    rf_wr_t     [NUM_WR_PORTS-1:0] wr_nxt, wr_q;
    logic                          pc_en_nxt, end_nxt;
    double_word                    pc_nxt;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        wb_lane u_lane (
            .result    (lanes.lane_result[g]),
            .is_branch (lanes.lane_is_branch[g]),
            .write_rd  (lanes.lane_write_rd[g]),
            .rd        (lanes.lane_rd[g]),
            .uses_port (uses_port[g]),
            .wr_val    (wr_val[g]),
            .target    (target[g])
        );
    end

    // Walk lanes oldest-first. The first valid lane that cannot go, or any
    // accepted branch/end lane, closes the window for every younger lane.
    always_comb begin
        logic stop;
        int   used;
        stop      = done_executing;
        used      = 0;
        ready     = '0;
        wr_nxt    = '0;
        pc_en_nxt = 1'b0;
        pc_nxt    = '0;
        end_nxt   = 1'b0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (lanes.lane_valid[i]) begin
                if (stop || (uses_port[i] && used == NUM_WR_PORTS)) begin
                    stop = 1'b1;
                end else begin
                    ready[i] = 1'b1;
                    if (uses_port[i]) begin
                        for (int p = 0; p < NUM_WR_PORTS; p++) begin
                            if (p == used) begin
                                wr_nxt[p].we   = 1'b1;
                                wr_nxt[p].addr = lanes.lane_rd[i];
                                wr_nxt[p].data = wr_val[i];
                            end
                        end
                        used = used + 1;
                    end
                    if (lanes.lane_is_branch[i]) begin
                        pc_en_nxt = 1'b1;
                        pc_nxt    = target[i];
                        stop      = 1'b1;
                    end
                    if (lanes.lane_end_program[i]) begin
                        end_nxt = 1'b1;
                        stop    = 1'b1;
                    end
                end
            end
        end
    end

    assign lanes.lane_ready = ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q           <= '0;
            pc_write_en    <= 1'b0;
            pc_write       <= '0;
            done_executing <= 1'b0;
        end else begin
            wr_q        <= wr_nxt;
            pc_write_en <= pc_en_nxt;
            pc_write    <= pc_nxt;
            if (end_nxt) done_executing <= 1'b1;
        end
    end

    for (genvar p = 0; p < NUM_WR_PORTS; p++) begin : g_port
        assign rf_we[p]    = wr_q[p].we;
        assign rf_waddr[p] = wr_q[p].addr;
        assign rf_wdata[p] = wr_q[p].data;
    end

`ifdef WB_HISTORY_EN
    // Fed from the same next-state requests as rf_*, so history and the
    // register write become visible on the same edge.
    wb_history_buffer #(
        .HIST_DEPTH   (HIST_DEPTH),
        .NUM_WR_PORTS (NUM_WR_PORTS)
    ) u_hist (
        .clk        (clk),
        .rst        (rst),
        .wr         (wr_nxt),
        .hist_rd    (hist_rd),
        .hist_value (hist_value),
        .hist_valid (hist_valid)
    );
`else
    assign hist_rd    = '0;
    assign hist_value = '0;
    assign hist_valid = '0;
`endif

endmodule

// File: tb/tb_multi_lane_writeback.sv
// Bench for multi_lane_writeback: a 2-lane/1-port and a 4-lane/2-port
// instance checked every cycle against a lane-rule model, plus literal cases.
module tb_multi_lane_writeback;
    import cpu_pkg::*;

`ifdef WB_HISTORY_EN
    localparam bit HIST_ON = 1'b1;
`else
    localparam bit HIST_ON = 1'b0;
`endif

    logic clk, rst, chk_on;
    int   n_checks, n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus, index 0 = DUT A (2 lanes, 1 port), 1 = DUT B (4 lanes, 2 ports)
    logic       [1:0][3:0]      s_v, s_br, s_wr, s_ep;
    reg_idx_t   [1:0][3:0]      s_rd;
    double_word [1:0][3:0]      s_res;

    multi_lane_writeback_if #(.NUM_LANES(2)) ifa ();
    multi_lane_writeback_if #(.NUM_LANES(4)) ifb ();

    assign ifa.lane_valid       = s_v[0][1:0];
    assign ifa.lane_is_branch   = s_br[0][1:0];
    assign ifa.lane_write_rd    = s_wr[0][1:0];
    assign ifa.lane_end_program = s_ep[0][1:0];
    assign ifa.lane_rd          = s_rd[0][1:0];
    assign ifa.lane_result      = s_res[0][1:0];
    assign ifb.lane_valid       = s_v[1];
    assign ifb.lane_is_branch   = s_br[1];
    assign ifb.lane_write_rd    = s_wr[1];
    assign ifb.lane_end_program = s_ep[1];
    assign ifb.lane_rd          = s_rd[1];
    assign ifb.lane_result      = s_res[1];

    logic a_we, a_pcen, a_done, b_pcen, b_done;
    reg_idx_t a_wa;
    double_word a_wd, a_pc, b_pc;
    logic [1:0] b_we;
    reg_idx_t [1:0] b_wa;
    double_word [1:0] b_wd;
    reg_idx_t [3:0] a_hrd;
    double_word [3:0] a_hv;
    logic [3:0] a_hvld;
    reg_idx_t [2:0] b_hrd;
    double_word [2:0] b_hv;
    logic [2:0] b_hvld;

    multi_lane_writeback #(.NUM_LANES(2), .NUM_WR_PORTS(1), .HIST_DEPTH(4)) dut_a (
        .clk(clk), .rst(rst), .lanes(ifa),
        .rf_we(a_we), .rf_waddr(a_wa), .rf_wdata(a_wd),
        .pc_write_en(a_pcen), .pc_write(a_pc), .done_executing(a_done),
        .hist_rd(a_hrd), .hist_value(a_hv), .hist_valid(a_hvld)
    );

    multi_lane_writeback #(.NUM_LANES(4), .NUM_WR_PORTS(2), .HIST_DEPTH(3)) dut_b (
        .clk(clk), .rst(rst), .lanes(ifb),
        .rf_we(b_we), .rf_waddr(b_wa), .rf_wdata(b_wd),
        .pc_write_en(b_pcen), .pc_write(b_pc), .done_executing(b_done),
        .hist_rd(b_hrd), .hist_value(b_hv), .hist_valid(b_hvld)
    );

    // Outputs of both DUTs widened to a common shape
    logic       [1:0][3:0] o_rdy, o_hvld;
    logic       [1:0][1:0] o_we;
    reg_idx_t   [1:0][1:0] o_wa;
    double_word [1:0][1:0] o_wd;
    logic       [1:0]      o_pcen, o_done;
    double_word [1:0]      o_pc;
    reg_idx_t   [1:0][3:0] o_hrd;
    double_word [1:0][3:0] o_hv;

    assign o_rdy[0] = {2'b00, ifa.lane_ready};
    assign o_rdy[1] = ifb.lane_ready;
    assign o_we[0]  = {1'b0, a_we};
    assign o_we[1]  = b_we;
    assign o_wa[0]  = {5'd0, a_wa};
    assign o_wa[1]  = b_wa;
    assign o_wd[0]  = {64'd0, a_wd};
    assign o_wd[1]  = b_wd;
    assign o_pcen   = {b_pcen, a_pcen};
    assign o_pc     = {b_pc, a_pc};
    assign o_done   = {b_done, a_done};
    assign o_hrd[0] = a_hrd;
    assign o_hrd[1] = {5'd0, b_hrd};
    assign o_hv[0]  = a_hv;
    assign o_hv[1]  = {64'd0, b_hv};
    assign o_hvld[0] = a_hvld;
    assign o_hvld[1] = {1'b0, b_hvld};

    task automatic check(input string nm, input int d, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s dut%0d got=%h want=%h t=%0t", nm, d, act, exp, $time);
        end
    endtask

    // Lane i may go iff valid, not done, every older valid lane went and is
    // neither branch nor end, and the writes up to and including i fit.
    function automatic logic [3:0] model_ready(input int nl, input int np,
            input logic [3:0] v, input logic [3:0] br, input logic [3:0] ep,
            input logic [3:0] need, input logic done);
        logic [3:0] r;
        r = '0;
        for (int i = 0; i < nl; i++) begin
            bit ok;
            int writes;
            ok = v[i] && !done;
            writes = 0;
            for (int j = 0; j <= i; j++) begin
                if (v[j]) begin
                    writes += int'(need[j]);
                    if (j < i && (!r[j] || br[j] || ep[j])) ok = 0;
                end
            end
            r[i] = ok && (writes <= np);
        end
        return r;
    endfunction

    function automatic int cfg_lanes(input int d); return (d == 0) ? 2 : 4; endfunction
    function automatic int cfg_ports(input int d); return (d == 0) ? 1 : 2; endfunction
    function automatic int cfg_hist (input int d); return (d == 0) ? 4 : 3; endfunction

    function automatic logic [3:0] need_of(input int d);
        logic [3:0] n;
        for (int i = 0; i < 4; i++) n[i] = s_wr[d][i] && (s_rd[d][i] != 5'd0);
        return n;
    endfunction

    // Model state: expected registered outputs and history (entry 0 newest)
    logic       [1:0][1:0] e_we;
    reg_idx_t   [1:0][1:0] e_wa;
    double_word [1:0][1:0] e_wd;
    logic       [1:0]      e_pcen, e_done;
    double_word [1:0]      e_pc;
    reg_idx_t   m_hrd [2][4];
    double_word m_hv  [2][4];
    int         m_hn  [2];

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            logic [3:0] rdy, need;
            double_word tgt, val;
            int k, hd;
            hd = cfg_hist(d);
            if (rst) begin
                e_we[d] = '0; e_wa[d] = '0; e_wd[d] = '0;
                e_pcen[d] = 1'b0; e_pc[d] = '0; e_done[d] = 1'b0;
                m_hn[d] = 0;
                for (int j = 0; j < 4; j++) begin m_hrd[d][j] = '0; m_hv[d][j] = '0; end
            end else begin
                need = need_of(d);
                rdy = model_ready(cfg_lanes(d), cfg_ports(d), s_v[d], s_br[d], s_ep[d], need, e_done[d]);
                e_we[d] = '0; e_wa[d] = '0; e_wd[d] = '0;
                e_pcen[d] = 1'b0; e_pc[d] = '0;
                k = 0;
                for (int i = 0; i < cfg_lanes(d); i++) begin
                    if (rdy[i]) begin
                        tgt = s_res[d][i] & ~64'd1;
                        val = s_br[d][i] ? tgt + 64'd4 : s_res[d][i];
                        if (need[i]) begin
                            e_we[d][k] = 1'b1; e_wa[d][k] = s_rd[d][i]; e_wd[d][k] = val;
                            k++;
                            for (int j = 3; j > 0; j--) begin
                                m_hrd[d][j] = m_hrd[d][j-1]; m_hv[d][j] = m_hv[d][j-1];
                            end
                            m_hrd[d][0] = s_rd[d][i]; m_hv[d][0] = val;
                            if (m_hn[d] < hd) m_hn[d]++;
                        end
                        if (s_br[d][i]) begin e_pcen[d] = 1'b1; e_pc[d] = tgt; end
                        if (s_ep[d][i]) e_done[d] = 1'b1;
                    end
                end
            end
        end
    end

    // Compare mid-cycle: inputs settled since posedge+2, registers settled
    always @(negedge clk) begin
        if (chk_on) begin
            for (int d = 0; d < 2; d++) begin
                logic [3:0] r;
                int hd;
                hd = cfg_hist(d);
                r = model_ready(cfg_lanes(d), cfg_ports(d), s_v[d], s_br[d], s_ep[d], need_of(d), e_done[d]);
                check("lane_ready", d, 64'(o_rdy[d]), 64'(r));
                for (int p = 0; p < cfg_ports(d); p++) begin
                    check("rf_we",    d, 64'(o_we[d][p]), 64'(e_we[d][p]));
                    check("rf_waddr", d, 64'(o_wa[d][p]), 64'(e_wa[d][p]));
                    check("rf_wdata", d, o_wd[d][p], e_wd[d][p]);
                end
                check("pc_write_en", d, 64'(o_pcen[d]), 64'(e_pcen[d]));
                if (e_pcen[d]) check("pc_write", d, o_pc[d], e_pc[d]);
                check("done", d, 64'(o_done[d]), 64'(e_done[d]));
                for (int j = 0; j < 4; j++) begin
                    bit in_h;
                    in_h = HIST_ON && (j < hd);
                    check("hist_rd",    d, 64'(o_hrd[d][j]), in_h ? 64'(m_hrd[d][j]) : 64'd0);
                    check("hist_value", d, o_hv[d][j], in_h ? m_hv[d][j] : 64'd0);
                    check("hist_valid", d, 64'(o_hvld[d][j]), 64'(in_h && (j < m_hn[d])));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        s_v = '0; s_br = '0; s_wr = '0; s_ep = '0; s_rd = '0; s_res = '0;
    endtask

    task automatic set_a(input int l, input logic br, input logic wr, input logic ep,
                         input reg_idx_t rd, input double_word res);
        s_v[0][l] = 1'b1; s_br[0][l] = br; s_wr[0][l] = wr; s_ep[0][l] = ep;
        s_rd[0][l] = rd; s_res[0][l] = res;
    endtask

    initial begin
        n_checks = 0; n_fail = 0; chk_on = 1'b0;
        rst = 1'b1;
        idle();
        step(); step();
        check("rst_we",    0, 64'(o_we[0]), 64'd0);
        check("rst_waddr", 0, 64'(o_wa[0]), 64'd0);
        check("rst_wdata", 0, o_wd[0][0], 64'd0);
        check("rst_pcen",  0, 64'(a_pcen), 64'd0);
        check("rst_pc",    0, a_pc, 64'd0);
        check("rst_done",  0, 64'(a_done), 64'd0);
        check("rst_hvld",  0, 64'(a_hvld), 64'd0);
        check("rst_hrd",   0, 64'(a_hrd), 64'd0);
        rst = 1'b0; chk_on = 1'b1;

        // Two writers, one port: lane 0 now, lane 1 next cycle
        set_a(0, 0, 1, 0, 5'd5, 64'h55);
        set_a(1, 0, 1, 0, 5'd6, 64'h66);
        #1 check("r21_ready", 0, 64'(ifa.lane_ready), 64'b01);
        step();
        check("r21_we0",   0, 64'(a_we), 64'd1);
        check("r21_addr0", 0, 64'(a_wa), 64'd5);
        check("r21_data0", 0, a_wd, 64'h55);
        s_v[0][0] = 1'b0;
        #1 check("r21_ready1", 0, 64'(ifa.lane_ready), 64'b10);
        step();
        check("r21_addr1", 0, 64'(a_wa), 64'd6);
        check("r21_data1", 0, a_wd, 64'h66);

        // Branch with link
        idle(); set_a(0, 1, 1, 0, 5'd1, 64'h1001);
        step();
        check("r22_pcen", 0, 64'(a_pcen), 64'd1);
        check("r22_pc",   0, a_pc, 64'h1000);
        check("r22_data", 0, a_wd, 64'h1004);
        check("r22_addr", 0, 64'(a_wa), 64'd1);

        // Branch blocks a younger writer
        idle(); set_a(0, 1, 0, 0, 5'd0, 64'h2000); set_a(1, 0, 1, 0, 5'd7, 64'h77);
        #1 check("r23_ready", 0, 64'(ifa.lane_ready), 64'b01);
        step();
        check("r23_we", 0, 64'(a_we), 64'd0);
        check("r23_pc", 0, a_pc, 64'h2000);

        // x0 write consumes nothing
        idle(); set_a(0, 0, 1, 0, 5'd0, 64'hFF);
        #1 check("r24_ready", 0, 64'(ifa.lane_ready), 64'b01);
        step();
        check("r24_we",  0, 64'(a_we), 64'd0);
        check("r24_h0",  0, 64'(a_hrd[0]), HIST_ON ? 64'd1 : 64'd0);
        check("r24_h2",  0, 64'(a_hrd[2]), HIST_ON ? 64'd5 : 64'd0);

        // Five writes x1..x5 leave {5,4,3,2} in history
        for (int k = 1; k <= 5; k++) begin
            idle(); set_a(0, 0, 1, 0, reg_idx_t'(k), 64'(k * 16));
            step();
        end
        idle();
        check("r26_h0",  0, 64'(a_hrd[0]), HIST_ON ? 64'd5 : 64'd0);
        check("r26_h1",  0, 64'(a_hrd[1]), HIST_ON ? 64'd4 : 64'd0);
        check("r26_h2",  0, 64'(a_hrd[2]), HIST_ON ? 64'd3 : 64'd0);
        check("r26_h3",  0, 64'(a_hrd[3]), HIST_ON ? 64'd2 : 64'd0);
        check("r26_hv0", 0, a_hv[0], HIST_ON ? 64'd80 : 64'd0);
        check("r26_vld", 0, 64'(a_hvld), HIST_ON ? 64'hF : 64'd0);

        // End of program is sticky and stalls everything until reset
        idle(); set_a(0, 0, 0, 1, 5'd0, 64'h0); set_a(1, 0, 1, 0, 5'd9, 64'h99);
        #1 check("r25_ready", 0, 64'(ifa.lane_ready), 64'b01);
        step();
        check("r25_done", 0, 64'(a_done), 64'd1);
        check("r25_we",   0, 64'(a_we), 64'd0);
        idle(); set_a(0, 0, 1, 0, 5'd3, 64'h33); set_a(1, 0, 1, 0, 5'd4, 64'h44);
        #1 check("r25_stall", 0, 64'(ifa.lane_ready), 64'b00);
        step(); step();
        check("r25_hold", 0, 64'(a_done), 64'd1);
        check("r25_nowr", 0, 64'(a_we), 64'd0);
        rst = 1'b1; step(); rst = 1'b0;
        check("r25_clr", 0, 64'(a_done), 64'd0);

        // Random traffic with occasional resets, some landing on accepted lanes
        for (int n = 0; n < 3000; n++) begin
            idle();
            rst = ($urandom_range(0, 39) == 0) || (e_done == 2'b11);
            for (int d = 0; d < 2; d++) begin
                for (int i = 0; i < cfg_lanes(d); i++) begin
                    s_v[d][i]   = ($urandom_range(0, 3) != 0);
                    s_wr[d][i]  = ($urandom_range(0, 4) != 0);
                    s_br[d][i]  = ($urandom_range(0, 7) == 0);
                    s_ep[d][i]  = ($urandom_range(0, 39) == 0);
                    s_rd[d][i]  = reg_idx_t'($urandom_range(0, 7));
                    s_res[d][i] = {$urandom, $urandom};
                end
            end
            step();
        end
        rst = 1'b0; idle();
        step(); step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
